// File: rtl/ccsds_sync_pkg.sv
// Shared constants and state encoding for the ASM inserter / pseudo-randomizer.
// The LFSR tap mask matches h(x)=x^8+x^7+x^5+x^3+1 with the output taken from bit 7.
package ccsds_sync_pkg;

  localparam logic [31:0] ASM_DEFAULT = 32'h1ACFFC1D;
  localparam logic [7:0]  PN_SEED     = 8'hFF;
  // Bits 7,4,2,0 feed back: a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n] with a[n] at bit 7.
  localparam logic [7:0]  PN_TAPS     = 8'h95;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ASM  = 2'd1,
    S_DATA = 2'd2
  } sync_state_t;

  function automatic logic pn_feedback(input logic [7:0] r);
    return ^(r & PN_TAPS);
  endfunction

endpackage

// File: rtl/ccsds_asm_randomizer_if.sv
// Bit-serial AXI-Stream bundle; master drives data/valid/last/user, slave drives ready.
interface ccsds_asm_randomizer_if;
  logic tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ccsds_pn_gen.sv
// CCSDS pseudo-randomizer bit generator: 8-bit Fibonacci LFSR, output from the MSB.
module ccsds_pn_gen
  import ccsds_sync_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic adv,
  output logic pn_bit
);

  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PN_SEED;
    end else if (init) begin
      lfsr <= PN_SEED;
    end else if (adv) begin
      lfsr <= {lfsr[6:0], pn_feedback(lfsr)};
    end
  end

  assign pn_bit = lfsr[7];

endmodule

// File: rtl/ccsds_asm_randomizer.sv
// Prepends the attached sync marker to each codeblock and (with CCSDS_RANDOMIZER_EN
// defined) XORs the code bits with the CCSDS PN sequence; otherwise code bits pass through.
//
//   state  | meaning
//   S_IDLE | waiting for the first bit of a frame (one bubble cycle)
//   S_ASM  | emitting marker bits MSB first
//   S_DATA | passing code bits until input tlast
module ccsds_asm_randomizer
  import ccsds_sync_pkg::*;
#(
  parameter logic [31:0] ASM_PATTERN = ASM_DEFAULT,
  parameter int          ASM_LEN     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ccsds_asm_randomizer_if.slave           s_axis,
  ccsds_asm_randomizer_if.master          m_axis
);

  localparam logic [4:0] ASM_LAST = 5'(ASM_LEN - 1);

  sync_state_t state;
  logic [4:0]  cnt;
  logic        ld;
  logic        take;
  logic        code_bit;

  assign ld            = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tready = (state == S_DATA) && ld;
  assign take          = s_axis.tready && s_axis.tvalid;

`ifdef CCSDS_RANDOMIZER_EN
  logic pn_bit;

  // Reload on the frame's last bit so the next frame starts from the seed.
  ccsds_pn_gen u_pn_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (take && s_axis.tlast),
    .adv    (take),
    .pn_bit (pn_bit)
  );

  assign code_bit = s_axis.tdata ^ pn_bit;
`else
  assign code_bit = s_axis.tdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      m_axis.tdata  <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (ld) begin
      case (state)
        S_IDLE: begin
          m_axis.tvalid <= 1'b0;
          if (s_axis.tvalid) begin
            state <= S_ASM;
          end
        end
        S_ASM: begin
          m_axis.tdata  <= ASM_PATTERN[5'd31 - cnt];
          m_axis.tvalid <= 1'b1;
          m_axis.tuser  <= (cnt == 5'd0);
          m_axis.tlast  <= 1'b0;
          if (cnt == ASM_LAST) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_DATA: begin
          if (s_axis.tvalid) begin
            m_axis.tdata  <= code_bit;
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= s_axis.tlast;
            m_axis.tuser  <= 1'b0;
            if (s_axis.tlast) begin
              state <= S_IDLE;
            end
          end else begin
            m_axis.tvalid <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          cnt           <= '0;
          m_axis.tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccsds_asm_randomizer.sv
// Scoreboard bench for ccsds_asm_randomizer: expected bits are queued at stimulus time
// and popped by an independent monitor on every output transfer.
module tb_ccsds_asm_randomizer;

  localparam logic [31:0] ASM_WORD = 32'h1ACFFC1D;
  localparam int          MARKER_BITS = 32;

  typedef struct packed {
    logic d;
    logic l;
    logic u;
  } exp_t;

  logic clk;
  logic rst_n;

  ccsds_asm_randomizer_if s_if ();
  ccsds_asm_randomizer_if m_if ();

  ccsds_asm_randomizer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if.slave),
    .m_axis (m_if.master)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   frame_bits[$];
  bit   rnd_ready = 0;
  int   gap_pct = 0;
  bit   bubble_chk = 0;
  int   last_tlast_cyc = -1;
  int   cyc = 0;

`ifdef CCSDS_RANDOMIZER_EN
  bit pn_seq[8192];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Downstream ready: always high, or a fair coin when rnd_ready is set.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit       prev_stall;
    bit [2:0] prev_bits;
    exp_t     e;
    prev_stall = 0;
    prev_bits  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (!m_if.tvalid || {m_if.tdata, m_if.tlast, m_if.tuser} != prev_bits) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b bits=%b want valid=1 bits=%b",
                   m_if.tvalid, {m_if.tdata, m_if.tlast, m_if.tuser}, prev_bits);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got d/l/u=%b want no output",
                   {m_if.tdata, m_if.tlast, m_if.tuser});
        end else begin
          e = exp_q.pop_front();
          if ({m_if.tdata, m_if.tlast, m_if.tuser} != e) begin
            errors++;
            $display("FAIL out_bit: got d/l/u=%b want %b (remaining %0d)",
                     {m_if.tdata, m_if.tlast, m_if.tuser}, e, exp_q.size());
          end
        end
        if (bubble_chk && m_if.tuser && last_tlast_cyc >= 0) begin
          checks++;
          if (cyc - last_tlast_cyc != 2) begin
            errors++;
            $display("FAIL frame_gap: got %0d cycles tlast->tuser want 2", cyc - last_tlast_cyc);
          end
        end
        if (m_if.tlast) last_tlast_cyc = cyc;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_bits  = {m_if.tdata, m_if.tlast, m_if.tuser};
    end
  end

  // Reference: marker is the top MARKER_BITS of ASM_WORD, then code bits XOR PN from index 0.
  task automatic push_expected();
    int n;
    n = frame_bits.size();
    for (int k = 0; k < MARKER_BITS; k++)
      exp_q.push_back('{d: ASM_WORD[31-k], l: 1'b0, u: (k == 0)});
    for (int i = 0; i < n; i++) begin
      bit b;
      b = frame_bits[i];
`ifdef CCSDS_RANDOMIZER_EN
      b = b ^ pn_seq[i % 255];
`endif
      exp_q.push_back('{d: b, l: (i == n - 1), u: 1'b0});
    end
  endtask

  task automatic send_frame(input int abort_at);
    int n;
    n = frame_bits.size();
    push_expected();
    for (int i = 0; i < n; i++) begin
      int wait_cnt;
      bit acc;
      while ($urandom_range(0, 99) < gap_pct) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = frame_bits[i];
      s_if.tlast  = (i == n - 1);
      wait_cnt = 0;
      acc = 0;
      while (!acc && wait_cnt < 2000) begin
        @(negedge clk);
        if (s_if.tready) acc = 1;
        else wait_cnt++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL input_accept: got no tready within 2000 cycles at bit %0d want accept", i);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i + 1 == abort_at) begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        return;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d bits outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    bit [4:0] got;
    got = {m_if.tdata, m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready};
    checks++;
    if (got != 5'b0) begin
      errors++;
      $display("FAIL %s: got data/valid/last/user/s_ready=%b want 00000", name, got);
    end
  endtask

  task automatic fill_const(input int n, input bit v);
    frame_bits.delete();
    for (int i = 0; i < n; i++) frame_bits.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    frame_bits.delete();
    for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [15:0] pat16;
`ifdef CCSDS_RANDOMIZER_EN
    for (int n = 0; n < 8192; n++)
      pn_seq[n] = (n < 8) ? 1'b1 : (pn_seq[n-1] ^ pn_seq[n-3] ^ pn_seq[n-5] ^ pn_seq[n-8]);
`endif
    rst_n       = 1'b0;
    s_if.tdata  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-size all-zero codeblock.
    fill_const(8160, 1'b0);
    send_frame(0);
    drain("zeros_8160");

    fill_const(64, 1'b1);
    send_frame(0);
    drain("ones_64");

    // Back-to-back frames: exactly one bubble between tlast and the next marker.
    bubble_chk = 1;
    last_tlast_cyc = -1;
    fill_rand(16);
    send_frame(0);
    fill_rand(16);
    send_frame(0);
    drain("back_to_back");
    bubble_chk = 0;

    // Random back-pressure and input gaps, including a 1-bit frame.
    rnd_ready = 1;
    gap_pct = 30;
    fill_rand(1);
    send_frame(0);
    fill_rand(int'($urandom_range(2, 150)));
    send_frame(0);
    fill_rand(int'($urandom_range(2, 150)));
    send_frame(0);
    drain("random_stall");
    rnd_ready = 0;
    gap_pct = 0;

    // Reset after code bit 100 is accepted; the partial frame is abandoned.
    fill_rand(300);
    send_frame(100);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    fill_rand(40);
    send_frame(0);
    drain("after_reset");

    pat16 = 16'hA5A5;
    frame_bits.delete();
    for (int i = 15; i >= 0; i--) frame_bits.push_back(pat16[i]);
    send_frame(0);
    drain("a5a5");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccsds_asm_randomizer.md
Name: ccsds_asm_randomizer

Overview:
- Downstream neighbour of the CCSDS LDPC encoder: consumes the encoder's bit-serial codeblock stream.
- Emits one 32-bit Attached Sync Marker (ASM), then the codeblock bits XORed with the CCSDS pseudo-randomizer sequence.
- Bit-serial AXI-Stream on both sides. Feeds the modulator / transfer-frame output interface.
- One registered output stage gives one bubble cycle per codeblock; otherwise 1 bit/clk.

Parameters:
- ASM_PATTERN, 32'h1ACFFC1D, sync marker transmitted MSB first.
- ASM_LEN, 32, marker length in bits (1..32); the marker is the top ASM_LEN bits of ASM_PATTERN, sent MSB first.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  1  coded bit from encoder
- s_axis_tvalid  input  1  input bit valid
- s_axis_tready  output  1  ready to accept input bit
- s_axis_tlast  input  1  last bit of codeblock
- m_axis_tdata  output  1  output bit (ASM or randomized code bit)
- m_axis_tvalid  output  1  output valid
- m_axis_tlast  output  1  high on last code bit of each frame
- m_axis_tuser  output  1  high on first ASM bit of each frame
- m_axis_tready  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; ASM counter 0; PN register 8'hFF.
  - All m_axis_* outputs 0; s_axis_tready 0.
- Load enable: ld = !m_axis_tvalid || m_axis_tready. The output register updates only when ld=1.
- Output stability: tdata, tlast and tuser are held stable while m_axis_tvalid && !m_axis_tready.
- IDLE:
  - s_axis_tready=0.
  - If s_axis_tvalid=1, go to ASM. The input bit is not consumed; this is the one bubble cycle.
- ASM:
  - s_axis_tready=0.
  - On ld: m_axis_tdata <= ASM_PATTERN[31-cnt]; m_axis_tvalid <= 1; m_axis_tuser <= (cnt==0); m_axis_tlast <= 0; cnt++.
  - When cnt==ASM_LEN-1 is loaded: cnt <= 0, go to DATA.
- DATA:
  - s_axis_tready = ld (combinational).
  - On ld with s_axis_tvalid: m_axis_tdata <= s_axis_tdata ^ pn_bit; m_axis_tvalid <= 1; m_axis_tlast <= s_axis_tlast; m_axis_tuser <= 0; PN advances.
  - If s_axis_tlast: go to IDLE and reload PN with 8'hFF.
  - On ld without s_axis_tvalid: m_axis_tvalid <= 0 (gaps are permitted mid-frame; PN does not advance).
- IDLE/ASM ld without new bit: m_axis_tvalid <= 0.
- PN sequence:
  - Polynomial h(x)=x^8+x^7+x^5+x^3+1, seed all ones, period 255 bits.
  - First 32 output bits are 0xFF480EC0, MSB first.
  - Restarts at the first code bit of every frame.
  - Wrap after 255 bits is natural LFSR periodicity and needs no special handling.
- Frame length:
  - Not checked; the frame is delimited solely by s_axis_tlast.
  - A 1-bit frame (tlast on first bit) is legal: ASM, one bit XOR 1, tlast.
- Back-pressure: m_axis_tready held low freezes state, counter and PN; no bits are lost or duplicated.
- Reset mid-frame:
  - Immediate return to the reset state.
  - The partial frame is dropped.
  - The next frame starts with a full ASM.
- Back-to-back frames: after an input tlast the next frame costs exactly one bubble cycle (IDLE) before its ASM.

Optional Feature:
- Macro: CCSDS_RANDOMIZER_EN.
- Defined: code bits are XORed with the PN sequence as above.
- Undefined:
  - No PN generator is instantiated.
  - Code bits pass through unmodified.
  - ASM insertion, framing and handshake are identical.

Decomposition:
- Package ccsds_sync_pkg holds:
  - ASM default constant 32'h1ACFFC1D;
  - PN seed 8'hFF and tap mask;
  - state encoding IDLE/ASM/DATA (2 bits).
- Sub-module ccsds_pn_gen:
  - Ports: clk, rst_n, init, adv, pn_bit.
  - 8-bit LFSR; output taken from the register MSB.
  - init reloads the seed; adv steps one bit.

Test Plan:
- Single frame, 8160 input bits all 0, m_axis_tready=1:
  - 32 ASM bits 0x1ACFFC1D, tuser on bit 0.
  - Code bits begin 0xFF480EC0.
  - tlast on output bit 8192.
  - Total 8192 valid bits.
- Input all 1s, 64 bits → code-bit output is the bitwise NOT of the PN sequence: first 32 are 0x00B7F13F.
- Two back-to-back frames of 16 bits each:
  - Exactly one idle cycle between the first frame's tlast and the second ASM.
  - PN restarts at 0xFF48 for the second frame.
- Random m_axis_tready (50%) and random s_axis_tvalid gaps over 3 frames → output bit stream matches the reference model exactly; tdata is stable while stalled.
- Assert rst_n=0 at code bit 100 of a frame → all outputs 0 asynchronously; the next frame starts with a full ASM and PN 0xFF.
- Build without CCSDS_RANDOMIZER_EN, input 0xA5A5 pattern → output is the ASM followed by 0xA5A5 unmodified.
